// File: rtl/pocket_joypad_pkg.sv
// Shared constants for the pocket joypad controller: button lane layout,
// parameter defaults and a small width helper for the free-running counters.
package pocket_joypad_pkg;

    // Buttons per player lane
    localparam int unsigned NUM_BUTTONS = 16;

    // Bit index of each button inside a 16-bit lane
    typedef enum logic [3:0] {
        BTN_U  = 4'd0,
        BTN_D  = 4'd1,
        BTN_L  = 4'd2,
        BTN_R  = 4'd3,
        BTN_A  = 4'd4,
        BTN_B  = 4'd5,
        BTN_X  = 4'd6,
        BTN_Y  = 4'd7,
        BTN_L1 = 4'd8,
        BTN_R1 = 4'd9,
        BTN_L2 = 4'd10,
        BTN_R2 = 4'd11,
        BTN_L3 = 4'd12,
        BTN_R3 = 4'd13,
        BTN_SE = 4'd14,
        BTN_ST = 4'd15
    } btn_e;

    // Parameter defaults
    localparam int unsigned DEF_NUM_PLAYERS = 2;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DEB_TICK    = 1024;
    localparam int unsigned DEF_DEB_SAMPLES = 3;
    localparam int unsigned DEF_TURBO_HALF  = 2**20;

    // Sample counter width; DEB_SAMPLES never exceeds 15
    localparam int unsigned DEB_CNT_W = 4;

    // Width of a counter that runs 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/joypad_debounce_bit.sv
// One button: input synchronizer, tick-sampled debouncer with a consecutive
// disagreement counter, registered press/release pulses and turbo gating.
module joypad_debounce_bit
    import pocket_joypad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEB_SAMPLES = DEF_DEB_SAMPLES
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic raw,
    input  logic tick,
    input  logic turbo_en,
    input  logic phase,
    output logic key,
    output logic deb,
    output logic press,
    output logic release_pulse
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   deb_q;
    logic                   deb_nxt;
    logic [DEB_CNT_W-1:0]   cnt_q;
    logic [DEB_CNT_W-1:0]   cnt_nxt;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous key input
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Next debounce state: only a tick advances it, any agreeing sample restarts the count
    always_comb begin
        deb_nxt = deb_q;
        cnt_nxt = cnt_q;
        if (tick) begin
            if (synced == deb_q) begin
                cnt_nxt = '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_nxt = ~deb_q;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    // Debounce state plus edge pulses aligned to the cycle after DEB changes
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            deb_q         <= 1'b0;
            cnt_q         <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            deb_q         <= deb_nxt;
            cnt_q         <= cnt_nxt;
            press         <= deb_nxt & ~deb_q;
            release_pulse <= ~deb_nxt & deb_q;
        end
    end

    assign deb = deb_q;
    assign key = deb_q & (~turbo_en | phase);

endmodule

// File: rtl/pocket_joypad_ctrl.sv
// Multi-player joypad front end: shared debounce tick and turbo phase
// generation, one debouncer per button, and the any-button summary.
module pocket_joypad_ctrl
    import pocket_joypad_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEB_TICK    = DEF_DEB_TICK,
    parameter int unsigned DEB_SAMPLES = DEF_DEB_SAMPLES,
    parameter int unsigned TURBO_HALF  = DEF_TURBO_HALF
) (
    input  logic                               iCLK,
    input  logic                               iRST,
    input  logic [32*NUM_PLAYERS-1:0]          iJOY,
    input  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] iTURBO_EN,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] oKEY,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] oPRESS,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] oRELEASE,
    output logic                               oANY
);

    localparam int unsigned NB      = NUM_BUTTONS * NUM_PLAYERS;
    localparam int unsigned TICK_W  = cnt_width(DEB_TICK);
    localparam int unsigned TURBO_W = cnt_width(TURBO_HALF);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DEB_TICK - 1);
    localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_HALF - 1);

    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [TURBO_W-1:0] turbo_cnt;
    logic               phase;
    logic [NB-1:0]      deb_all;
    logic [NB-1:0]      unused_joy_hi;

    // Free-running debounce sample divider; tick is decoded from the count
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running turbo half-period divider; phase starts high after reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            turbo_cnt <= '0;
            phase     <= 1'b1;
        end else if (turbo_cnt == TURBO_LAST) begin
            turbo_cnt <= '0;
            phase     <= ~phase;
        end else begin
            turbo_cnt <= turbo_cnt + TURBO_W'(1);
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        // Upper half of each raw key word carries nothing we use
        assign unused_joy_hi[p*NUM_BUTTONS +: NUM_BUTTONS] = iJOY[p*32+16 +: 16];

        for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
            localparam int unsigned LANE = p * NUM_BUTTONS + b;

            joypad_debounce_bit #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_SAMPLES (DEB_SAMPLES)
            ) u_bit (
                .iCLK          (iCLK),
                .iRST          (iRST),
                .raw           (iJOY[p*32 + b]),
                .tick          (tick),
                .turbo_en      (iTURBO_EN[LANE]),
                .phase         (phase),
                .key           (oKEY[LANE]),
                .deb           (deb_all[LANE]),
                .press         (oPRESS[LANE]),
                .release_pulse (oRELEASE[LANE])
            );
        end
    end

    assign oANY = |deb_all;

endmodule

// File: tb/tb_pocket_joypad_ctrl.sv
// Directed bench for pocket_joypad_ctrl: expected output snapshots are queued
// per clock cycle as stimulus is applied and compared on the falling edge.
module tb_pocket_joypad_ctrl;
    import pocket_joypad_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DT = 1;
    localparam int unsigned DS = 3;
    localparam int unsigned TH = 4;
    localparam int unsigned NB = NUM_BUTTONS * NP;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [32*NP-1:0]  iJOY;
    logic [NB-1:0]     iTURBO_EN;
    logic [NB-1:0]     oKEY;
    logic [NB-1:0]     oPRESS;
    logic [NB-1:0]     oRELEASE;
    logic              oANY;

    typedef struct {
        int unsigned   cyc;
        string         tag;
        logic [NB-1:0] key;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic          any;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc      = 0;
    int unsigned checks   = 0;
    int unsigned passed   = 0;
    int unsigned failed   = 0;
    int unsigned rst_edge = 0;

    pocket_joypad_ctrl #(
        .NUM_PLAYERS (NP),
        .SYNC_STAGES (SS),
        .DEB_TICK    (DT),
        .DEB_SAMPLES (DS),
        .TURBO_HALF  (TH)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iJOY      (iJOY),
        .iTURBO_EN (iTURBO_EN),
        .oKEY      (oKEY),
        .oPRESS    (oPRESS),
        .oRELEASE  (oRELEASE),
        .oANY      (oANY)
    );

    always #5 iCLK = ~iCLK;

    // Number of rising edges seen so far
    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic logic [NB-1:0] bit_v(input int unsigned i);
        logic [NB-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Turbo phase after edge c, counted from the last edge that saw reset
    function automatic logic phase_at(input int unsigned c);
        return (((c - rst_edge) / TH) % 2) == 0;
    endfunction

    function automatic void push(input int unsigned c, input string tag,
                                 input logic [NB-1:0] k, input logic [NB-1:0] p,
                                 input logic [NB-1:0] r, input logic a);
        exp_t e;
        e.cyc = c; e.tag = tag; e.key = k; e.press = p; e.rel = r; e.any = a;
        sb.push_back(e);
    endfunction

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance so the next input change is captured at rising edge k
    task automatic step_to(input int unsigned k);
        while (cyc + 1 < k) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    // Scoreboard consumer: compare every queued snapshot due this cycle
    always @(negedge iCLK) begin : mon
        exp_t e;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.cyc == cyc) passed++;
            else begin
                failed++;
                $error("FAIL %s.cycle observed=%0d expected=%0d", e.tag, cyc, e.cyc);
            end
            check($sformatf("%s.key@%0d", e.tag, cyc), oKEY, e.key);
            check($sformatf("%s.press@%0d", e.tag, cyc), oPRESS, e.press);
            check($sformatf("%s.release@%0d", e.tag, cyc), oRELEASE, e.rel);
            check($sformatf("%s.any@%0d", e.tag, cyc), NB'(oANY), NB'(e.any));
        end
    end

    initial begin
        iRST      = 1'b1;
        iJOY      = '0;
        iTURBO_EN = '0;

        // Reset held for edges 1..3, outputs quiet afterwards
        for (int unsigned c = 1; c < 10; c++) push(c, "reset", '0, '0, '0, 1'b0);
        step_to(4);
        iRST     = 1'b0;
        rst_edge = 3;

        // Clean press on A (bit 4) captured at edge 10 -> DEB at edge 14
        step_to(10);
        for (int unsigned c = 10; c < 20; c++)
            push(c, "press_a", (c >= 14) ? bit_v(int'(BTN_A)) : '0,
                 (c == 14) ? bit_v(int'(BTN_A)) : '0, '0, c >= 14);
        iJOY[int'(BTN_A)] = 1'b1;

        // Clean release captured at edge 20 -> DEB falls at edge 24
        step_to(20);
        for (int unsigned c = 20; c < 26; c++)
            push(c, "release_a", (c < 24) ? bit_v(int'(BTN_A)) : '0, '0,
                 (c == 24) ? bit_v(int'(BTN_A)) : '0, c < 24);
        iJOY[int'(BTN_A)] = 1'b0;

        // Two-cycle glitch on U (bit 0) never qualifies
        step_to(30);
        for (int unsigned c = 29; c < 42; c++) push(c, "glitch_u", '0, '0, '0, 1'b0);
        iJOY[int'(BTN_U)] = 1'b1;
        step_to(32);
        iJOY[int'(BTN_U)] = 1'b0;

        // Turbo on B (bit 5): 4 high / 4 low while oANY stays high
        step_to(50);
        for (int unsigned c = 50; c < 77; c++)
            push(c, "turbo_b", (c >= 54 && phase_at(c)) ? bit_v(int'(BTN_B)) : '0,
                 (c == 54) ? bit_v(int'(BTN_B)) : '0, '0, c >= 54);
        iTURBO_EN[int'(BTN_B)] = 1'b1;
        iJOY[int'(BTN_B)]      = 1'b1;

        // Turbo disabled: solid high from the same cycle
        step_to(78);
        for (int unsigned c = 77; c < 89; c++)
            push(c, "solid_b", bit_v(int'(BTN_B)), '0, '0, 1'b1);
        iTURBO_EN[int'(BTN_B)] = 1'b0;

        step_to(85);
        push(89, "release_b", '0, '0, bit_v(int'(BTN_B)), 1'b0);
        push(90, "release_b", '0, '0, '0, 1'b0);
        iJOY[int'(BTN_B)] = 1'b0;

        // Player 3 ST (iJOY[111]) only touches lane 63
        step_to(100);
        for (int unsigned c = 100; c < 110; c++)
            push(c, "p3_st", (c >= 104) ? bit_v(63) : '0,
                 (c == 104) ? bit_v(63) : '0, '0, c >= 104);
        iJOY[111] = 1'b1;

        // Reset pulse at edge 110 while held: no release, requalify by edge 115
        step_to(110);
        push(110, "rst_held", '0, '0, '0, 1'b0);
        iRST = 1'b1;
        step_to(111);
        iRST     = 1'b0;
        rst_edge = 110;
        for (int unsigned c = 111; c < 121; c++)
            push(c, "requal", (c >= 115) ? bit_v(63) : '0,
                 (c == 115) ? bit_v(63) : '0, '0, c >= 115);

        step_to(125);
        checks++;
        assert (sb.size() == 0) passed++;
        else begin
            failed++;
            $error("FAIL sb_drained observed=%0d expected=0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
